// File: rtl/iccm_loader_pkg.sv
// Shared types and constants for the ICCM boot loader.
// The optional checksum stage is compiled in with LOADER_CHECKSUM_EN.
package iccm_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        EVAL,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_e;

    localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/loader_uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid or frame_err pulse at the centre of the stop bit.
module loader_uart_rx
    import iccm_loader_pkg::*;
#(
    parameter int ClksPerBit = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(ClksPerBit);
    localparam logic [CW-1:0] FULL = CW'(ClksPerBit - 1);
    localparam logic [CW-1:0] HALF = CW'(ClksPerBit / 2 - 1);

    logic            meta_q, sync_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = R_START;
            end
            R_START: begin
                // a line back high at mid start bit is a glitch, not a frame
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/iccm_loader.sv
// Boot loader: UART bytes -> little-endian words -> ICCM writes, then core release.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit sum word after EndWord.
module iccm_loader
    import iccm_loader_pkg::*;
#(
    parameter int          DataWidth  = 32,
    parameter int          AddrWidth  = 15,
    parameter int          ClksPerBit = 434,
    parameter logic [31:0] EndWord    = END_WORD_DEFAULT
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst_ni,
    input  logic                 uart_rx_i,
    output logic [AddrWidth-1:0] iccm_addr_o,
    output logic                 iccm_we_o,
    output logic [DataWidth-1:0] iccm_wdata_o,
    output logic                 core_rst_no,
    output logic                 load_busy_o,
    output logic                 load_done_o,
    output logic                 load_err_o
);

    localparam logic [AddrWidth-1:0] ADDR_MAX = '1;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    loader_uart_rx #(.ClksPerBit(ClksPerBit)) u_rx (
        .clk          (brq_clk),
        .rst_n        (brq_rst_ni),
        .rx_i         (uart_rx_i),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err)
    );

    loader_state_e        state_q, state_d;
    logic [DataWidth-1:0] word_q, word_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 full_q, full_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]          sum_q, sum_d;
`endif

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        full_d     = full_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
`ifdef LOADER_CHECKSUM_EN
            IDLE, RECV, CHECK: begin
`else
            IDLE, RECV: begin
`endif
                if (byte_valid) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == IDLE) state_d = RECV;
                    if (byte_cnt_q == 2'd3) begin
`ifdef LOADER_CHECKSUM_EN
                        if (state_q == CHECK) state_d = (word_d == sum_q) ? DONE : ERROR;
                        else
`endif
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                if (word_q == EndWord) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d    = CHECK;
                    byte_cnt_d = '0;
`else
                    state_d = DONE;
`endif
                end else if (full_q) begin
                    state_d = ERROR;
                end else begin
                    state_d = WRITE;
                    wdata_d = word_q;
                end
            end
            WRITE: begin
                // last location is written once; afterwards full_q blocks further words
                byte_cnt_d = '0;
                state_d    = RECV;
                if (addr_q == ADDR_MAX) full_d = 1'b1;
                else                    addr_d = addr_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                sum_d = sum_q + wdata_q;
`endif
            end
            default: ;
        endcase
        if (frame_err && state_q != DONE && state_q != ERROR) state_d = ERROR;
        busy_d = (state_d == RECV) || (state_d == EVAL) || (state_d == WRITE) || (state_d == CHECK);
        done_d = done_q || (state_d == DONE);
        err_d  = err_q || (state_d == ERROR);
    end

    always_ff @(posedge brq_clk or negedge brq_rst_ni) begin
        if (!brq_rst_ni) begin
            state_q    <= IDLE;
            word_q     <= '0;
            wdata_q    <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign iccm_addr_o  = addr_q;
    assign iccm_we_o    = (state_q == WRITE);
    assign iccm_wdata_o = wdata_q;
    assign core_rst_no  = done_q;
    assign load_busy_o  = busy_q;
    assign load_done_o  = done_q;
    assign load_err_o   = err_q;

endmodule

// File: tb/tb_iccm_loader.sv
// Directed bench for iccm_loader with ClksPerBit=16, AddrWidth=4.
// Checksum sequences run only when LOADER_CHECKSUM_EN is defined.
module tb_iccm_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;
    localparam logic [31:0] END_W = 32'h0000_0FFF;

    logic          brq_clk = 1'b0;
    logic          brq_rst_ni = 1'b0;
    logic          uart_rx_i = 1'b1;
    logic [AW-1:0] iccm_addr_o;
    logic          iccm_we_o;
    logic [31:0]   iccm_wdata_o;
    logic          core_rst_no, load_busy_o, load_done_o, load_err_o;

    iccm_loader #(.DataWidth(32), .AddrWidth(AW), .ClksPerBit(CPB), .EndWord(END_W)) dut (
        .brq_clk      (brq_clk),
        .brq_rst_ni   (brq_rst_ni),
        .uart_rx_i    (uart_rx_i),
        .iccm_addr_o  (iccm_addr_o),
        .iccm_we_o    (iccm_we_o),
        .iccm_wdata_o (iccm_wdata_o),
        .core_rst_no  (core_rst_no),
        .load_busy_o  (load_busy_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o)
    );

    always #5 brq_clk = ~brq_clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          bv_cnt = 0;
    logic [3:0]  wr_addr_last = '0;
    logic [31:0] wr_data_last = '0;
    logic        we_prev = 1'b0;

    // Write-port observer: the ICCM samples addr/data on the strobe edge.
    always @(posedge brq_clk) begin
        if (iccm_we_o) begin
            wr_cnt++;
            wr_addr_last = iccm_addr_o;
            wr_data_last = iccm_wdata_o;
            checks++;
            if (we_prev) begin
                errors++;
                $display("FAIL we_back_to_back: strobe high on consecutive cycles, required single-cycle");
            end
        end
        we_prev = iccm_we_o;
        if (dut.byte_valid) bv_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge brq_clk);
        uart_rx_i = 1'b0;
        repeat (CPB) @(negedge brq_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(negedge brq_clk);
        end
        uart_rx_i = stop;
        repeat (CPB) @(negedge brq_clk);
        uart_rx_i = 1'b1;
        repeat (4) @(negedge brq_clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    // EndWord, followed by the sum word when the checksum stage is built in
    task automatic send_end(input logic [31:0] sum);
        send_word(END_W);
`ifdef LOADER_CHECKSUM_EN
        send_word(sum);
`else
        if (sum == 32'hFFFF_FFFF) $display("note: unused sum");
`endif
    endtask

    task automatic do_reset();
        @(negedge brq_clk);
        brq_rst_ni = 1'b0;
        uart_rx_i  = 1'b1;
        repeat (3) @(negedge brq_clk);
        wr_cnt = 0;
        bv_cnt = 0;
        brq_rst_ni = 1'b1;
        repeat (2) @(negedge brq_clk);
    endtask

    typedef struct {
        logic [31:0] word;
        int          exp_wr_cnt;
        logic [3:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_done;
    } vec_t;

    vec_t vecs[4];
    int   n_vecs;

    initial begin
        vecs[0] = '{32'h0050_0013, 1, 4'd0, 32'h0050_0013, 1'b0};
        vecs[1] = '{32'h0050_0293, 2, 4'd1, 32'h0050_0293, 1'b0};
`ifdef LOADER_CHECKSUM_EN
        vecs[2] = '{END_W,         2, 4'd1, 32'h0050_0293, 1'b0};
        vecs[3] = '{32'h00A0_02A6, 2, 4'd1, 32'h0050_0293, 1'b1};
        n_vecs  = 4;
`else
        vecs[2] = '{END_W,         2, 4'd1, 32'h0050_0293, 1'b1};
        vecs[3] = '{32'h0,         0, 4'd0, 32'h0,         1'b0};
        n_vecs  = 3;
`endif

        // Reset state
        repeat (2) @(negedge brq_clk);
        chk("rst_addr", 32'(iccm_addr_o), 32'h0);
        chk("rst_we", 32'(iccm_we_o), 32'h0);
        chk("rst_wdata", iccm_wdata_o, 32'h0);
        chk("rst_core_rst_no", 32'(core_rst_no), 32'h0);
        chk("rst_busy", 32'(load_busy_o), 32'h0);
        chk("rst_done", 32'(load_done_o), 32'h0);
        chk("rst_err", 32'(load_err_o), 32'h0);
        do_reset();

        // Two-word image, table driven
        for (int v = 0; v < n_vecs; v++) begin
            send_word(vecs[v].word);
            chk($sformatf("img_wr_cnt[%0d]", v), 32'(wr_cnt), 32'(vecs[v].exp_wr_cnt));
            chk($sformatf("img_addr[%0d]", v), 32'(wr_addr_last), 32'(vecs[v].exp_addr));
            chk($sformatf("img_data[%0d]", v), wr_data_last, vecs[v].exp_data);
            chk($sformatf("img_done[%0d]", v), 32'(load_done_o), 32'(vecs[v].exp_done));
            chk($sformatf("img_core_rst[%0d]", v), 32'(core_rst_no), 32'(vecs[v].exp_done));
            chk($sformatf("img_busy[%0d]", v), 32'(load_busy_o), 32'(!vecs[v].exp_done));
        end
        send_word(32'h1234_5678);
        chk("done_ignores_bytes_wr", 32'(wr_cnt), 32'd2);
        chk("done_sticky", 32'(load_done_o), 32'h1);
        chk("done_no_err", 32'(load_err_o), 32'h0);

        // Framing error on the first byte
        do_reset();
        send_byte(8'h55, 1'b0);
        chk("ferr_err", 32'(load_err_o), 32'h1);
        chk("ferr_core_rst", 32'(core_rst_no), 32'h0);
        chk("ferr_busy", 32'(load_busy_o), 32'h0);
        chk("ferr_wr_cnt", 32'(wr_cnt), 32'h0);

        // Overflow: 16 words fill the ICCM, the 17th errors out
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_word(32'hA500_0000 | 32'(i));
            if (i < 16) begin
                chk($sformatf("ovf_wr_cnt[%0d]", i), 32'(wr_cnt), 32'(i + 1));
                chk($sformatf("ovf_addr[%0d]", i), 32'(wr_addr_last), 32'(i));
                chk($sformatf("ovf_data[%0d]", i), wr_data_last, 32'hA500_0000 | 32'(i));
                chk($sformatf("ovf_err_early[%0d]", i), 32'(load_err_o), 32'h0);
            end
        end
        chk("ovf_err", 32'(load_err_o), 32'h1);
        chk("ovf_wr_cnt", 32'(wr_cnt), 32'd16);
        chk("ovf_core_rst", 32'(core_rst_no), 32'h0);
        chk("ovf_busy", 32'(load_busy_o), 32'h0);

        // Reset after 6 bytes, then a clean 1-word image
        do_reset();
        send_word(32'h1111_1111);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        chk("mid_busy_before_rst", 32'(load_busy_o), 32'h1);
        chk("mid_addr_before_rst", 32'(iccm_addr_o), 32'h1);
        do_reset();
        chk("mid_rst_addr", 32'(iccm_addr_o), 32'h0);
        chk("mid_rst_busy", 32'(load_busy_o), 32'h0);
        send_word(32'hCAFE_F00D);
        chk("mid_wr_addr", 32'(wr_addr_last), 32'h0);
        chk("mid_wr_data", wr_data_last, 32'hCAFE_F00D);
        send_end(32'hCAFE_F00D);
        chk("mid_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("mid_done", 32'(load_done_o), 32'h1);

        // Start glitch shorter than half a bit
        do_reset();
        @(negedge brq_clk);
        uart_rx_i = 1'b0;
        repeat (CPB / 2 - 3) @(negedge brq_clk);
        uart_rx_i = 1'b1;
        repeat (3 * CPB) @(negedge brq_clk);
        chk("glitch_no_byte", 32'(bv_cnt), 32'h0);
        chk("glitch_busy", 32'(load_busy_o), 32'h0);
        chk("glitch_err", 32'(load_err_o), 32'h0);
        send_word(32'h0BAD_BEEF);
        chk("glitch_then_word", wr_data_last, 32'h0BAD_BEEF);
        chk("glitch_then_addr", 32'(wr_addr_last), 32'h0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        send_word(32'h1);
        send_word(32'h2);
        send_word(END_W);
        chk("cks_pending_done", 32'(load_done_o), 32'h0);
        send_word(32'h3);
        chk("cks_good_done", 32'(load_done_o), 32'h1);
        chk("cks_good_err", 32'(load_err_o), 32'h0);
        do_reset();
        send_word(32'h1);
        send_word(32'h2);
        send_word(END_W);
        send_word(32'h4);
        chk("cks_bad_err", 32'(load_err_o), 32'h1);
        chk("cks_bad_done", 32'(load_done_o), 32'h0);
        chk("cks_bad_core_rst", 32'(core_rst_no), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
